// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the square-root scheduler.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

  localparam int unsigned ROOT_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 3;

endpackage

// File: rtl/sqrt_scheduler_if.sv
// Requester-side request/response channels of the square-root scheduler.
interface sqrt_scheduler_if
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) ();

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             rsp_valid;
  logic [NREQ-1:0]             rsp_ready;
  logic [DATA_W-1:0]           rsp_data;
  logic                        rsp_err;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: highest priority at ptr, searching upward with wrap.
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ID_W'((32'(ptr) + k) % N);
      if (grant == '0 && (req & (N'(1) << idx)) != '0) begin
        grant     = N'(1) << idx;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/sqrt_scheduler.sv
// Round-robin scheduler sharing one square-root core among NREQ requesters, with a
// watchdog that turns a core that never finishes into an error response.
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  sqrt_scheduler_if.slave   bus,
  output logic              core_start,
  output logic [DATA_W-1:0] core_radicand,
  input  logic [DATA_W-1:0] core_root,
  input  logic              core_busy,
  input  logic              core_done,
  output logic              sched_busy,
  output logic [ID_W-1:0]   grant_id
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [DATA_W-1:0] rad_q, rad_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [NREQ-1:0]   arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic [NREQ-1:0]   rsp_mask;
  logic              unused_core;

  // busy is informational and the root is only 16 bits wide.
  assign unused_core = ^{core_busy, core_root[DATA_W-1:ROOT_W]};

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req      (bus.req_valid),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .grant_idx(arb_idx)
  );

  assign rsp_mask = NREQ'(1) << gid_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gid_d         = gid_q;
    rad_d         = rad_q;
    res_d         = res_q;
    err_d         = err_q;
    wd_d          = wd_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    core_start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = arb_grant;
        if (bus.req_valid != '0) begin
          for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) rad_d = bus.req_data[i];
          end
          gid_d   = arb_idx;
          ptr_d   = (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        wd_d       = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        // wd_q counts WAIT cycles; the last one is TIMEOUT-1 cycles after the start pulse,
        // so the error response appears exactly TIMEOUT cycles after it.
        if (core_done) begin
          res_d   = {{(DATA_W - ROOT_W){1'b0}}, core_root[ROOT_W-1:0]};
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WdW'(TIMEOUT - 2)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = rsp_mask;
        if ((bus.rsp_ready & rsp_mask) != '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      rad_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      rad_q   <= rad_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.rsp_data  = res_q;
  assign bus.rsp_err   = err_q;
  assign core_radicand = rad_q;
  assign sched_busy    = (state_q != IDLE);
  assign grant_id      = gid_q;

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Self-checking bench for sqrt_scheduler: directed scenarios plus randomized traffic
// against a transaction-level model with a behavioural square-root core.
module tb_sqrt_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 32;

  logic clk;
  logic reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0]       rsp_ready;
  logic        core_start, core_busy, core_done, sched_busy;
  logic [31:0] core_radicand, core_root;
  logic [2:0]  grant_id;

  sqrt_scheduler_if #(.NREQ(NREQ)) bus ();

  assign bus.req_valid = req_valid;
  assign bus.req_data  = req_data;
  assign bus.rsp_ready = rsp_ready;

  sqrt_scheduler #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .core_start   (core_start),
    .core_radicand(core_radicand),
    .core_root    (core_root),
    .core_busy    (core_busy),
    .core_done    (core_done),
    .sched_busy   (sched_busy),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint r = 0;
    longint t;
    for (int i = 15; i >= 0; i--) begin
      t = r | (longint'(1) << i);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] req);
    for (int k = 0; k < NREQ; k++) begin
      int j = (ptr + k) % NREQ;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // Behavioural core: done arrives core_lat cycles after the start cycle.
  int          core_cnt;
  logic [31:0] core_rad;
  int          core_lat;
  logic        core_hang, stray;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_cnt <= 0;
      core_rad <= '0;
    end else if (core_start) begin
      core_cnt <= core_hang ? 0 : core_lat;
      core_rad <= core_radicand;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign core_done = (core_cnt == 1) || stray;
  assign core_busy = (core_cnt != 0);
  assign core_root = 32'(isqrt(longint'(core_rad)));

  // Handshake logs used by the directed checks.
  int              acc_log[$];
  longint          rsp_log[$];
  logic [NREQ-1:0] acc_q;
  bit              auto_drop;

  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NREQ; i++) if (req_valid[i] && bus.req_ready[i]) acc_log.push_back(i);
      if ((bus.rsp_valid & rsp_ready) != '0) rsp_log.push_back(longint'(bus.rsp_data));
      acc_q = req_valid & bus.req_ready;
    end else begin
      acc_q = '0;
    end
  end

  // Transaction-level model: one request in flight, timed by cycle arithmetic.
  bit     m_busy, m_rsp, m_err;
  int     m_ptr, m_gid, m_tstart;
  longint m_rad, m_res;
  int     cyc = 0;

  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] exp_ready, exp_rsp;
    if (!reset_n) begin
      m_busy = 0; m_rsp = 0; m_err = 0;
      m_ptr = 0; m_gid = 0; m_rad = 0; m_res = 0;
    end
    w         = (!m_busy && req_valid != '0) ? rr_pick(m_ptr, req_valid) : -1;
    exp_ready = (w >= 0) ? NREQ'(1) << w : '0;
    exp_rsp   = m_rsp ? NREQ'(1) << m_gid : '0;
    chk("req_ready", longint'(bus.req_ready), longint'(exp_ready));
    chk("rsp_valid", longint'(bus.rsp_valid), longint'(exp_rsp));
    chk("core_start", longint'(core_start), longint'(m_busy && !m_rsp && cyc == m_tstart));
    chk("sched_busy", longint'(sched_busy), longint'(m_busy));
    chk("grant_id", longint'(grant_id), longint'(m_gid));
    chk("core_radicand", longint'(core_radicand), m_rad);
    if (m_rsp || !reset_n) begin
      chk("rsp_data", longint'(bus.rsp_data), m_res);
      chk("rsp_err", longint'(bus.rsp_err), longint'(m_err));
    end
    if (reset_n) begin
      if (w >= 0) begin
        m_busy   = 1;
        m_gid    = w;
        m_ptr    = (w + 1) % NREQ;
        m_rad    = longint'(req_data[w[1:0]]);
        m_tstart = cyc + 1;
      end else if (m_rsp) begin
        if (rsp_ready[m_gid[1:0]]) begin
          m_busy = 0;
          m_rsp  = 0;
        end
      end else if (m_busy && cyc > m_tstart) begin
        if (core_done) begin
          m_res = isqrt(m_rad); m_err = 0; m_rsp = 1;
        end else if (cyc - m_tstart == TIMEOUT - 1) begin
          m_res = 0; m_err = 1; m_rsp = 1;
        end
      end
    end
    cyc++;
  end

  // Inputs change at posedge+1, directed checks happen at negedge+1.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~acc_q;
  endtask

  task automatic negs();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    negs(); step(); negs(); step();
    reset_n = 1'b1;
    acc_log.delete();
    rsp_log.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    negs();
    while (sched_busy && n < 300) begin step(); negs(); n++; end
    chk(name, longint'(sched_busy), 0);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    negs();
    while (!core_start && n < 100) begin step(); negs(); n++; end
    chk(name, longint'(core_start), 1);
  endtask

  task automatic wait_rsp(input string name, input int sz);
    int n = 0;
    negs();
    while (rsp_log.size() < sz && n < 300) begin step(); negs(); n++; end
    chk(name, rsp_log.size(), sz);
  endtask

  function automatic longint q_at(input int idx, input bit from_rsp);
    if (from_rsp) return (idx < rsp_log.size()) ? rsp_log[idx] : -1;
    return (idx < acc_log.size()) ? longint'(acc_log[idx]) : -1;
  endfunction

  function automatic logic [31:0] rand_data();
    int unsigned k;
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'($urandom_range(0, 300));
      2:       return 32'hFFFF_FFFF;
      default: begin k = $urandom_range(0, 65535); return k * k; end
    endcase
  endfunction

  initial begin
    int n;
    int sz0;
    int exp3[5] = '{0, 1, 2, 3, 0};
    reset_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '1;
    core_hang = 1'b0; core_lat = 17; stray = 1'b0; auto_drop = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single request: accept in cycle 0, start in 1, response in 19.
    req_data[0] = 32'd144; req_valid = 4'b0001;
    negs(); chk("t1_ready_c0", longint'(bus.req_ready), 4'b0001);
    step(); negs(); chk("t1_start_c1", longint'(core_start), 1);
    repeat (17) begin step(); negs(); end
    chk("t1_no_rsp_c18", longint'(bus.rsp_valid), 0);
    step(); negs();
    chk("t1_rsp_valid_c19", longint'(bus.rsp_valid), 4'b0001);
    chk("t1_rsp_data", longint'(bus.rsp_data), 12);
    chk("t1_rsp_err", longint'(bus.rsp_err), 0);
    step();

    // Requesters 0 and 2, then the pointer must favour 3 over 0.
    do_reset();
    req_data[0] = 32'hFFFF_FFFF; req_data[2] = 32'd2; req_valid = 4'b0101;
    wait_rsp("t2_two_rsps", 2);
    chk("t2_first_grant", q_at(0, 0), 0);
    chk("t2_second_grant", q_at(1, 0), 2);
    chk("t2_first_root", q_at(0, 1), 65535);
    chk("t2_second_root", q_at(1, 1), 1);
    step();
    req_data[0] = 32'd5; req_data[3] = 32'd9; req_valid = 4'b1001;
    negs(); chk("t2_ptr_at_3", longint'(bus.req_ready), 4'b1000);
    step(); wait_idle("t2_idle");
    step();

    // All requesters held valid: grants rotate 0,1,2,3,0.
    do_reset();
    auto_drop = 1'b0;
    req_data = {32'd16, 32'd9, 32'd4, 32'd1}; req_valid = 4'b1111;
    n = 0; negs();
    while (acc_log.size() < 5 && n < 300) begin step(); negs(); n++; end
    for (int i = 0; i < 5; i++) chk($sformatf("t3_grant_%0d", i), q_at(i, 0), exp3[i]);
    step();
    req_valid = '0; auto_drop = 1'b1;
    wait_idle("t3_idle");
    step();

    // Core never finishes: error response TIMEOUT cycles after the start pulse.
    core_hang = 1'b1;
    req_data[1] = 32'd1000; req_valid = 4'b0010;
    wait_start("t5_start");
    n = 0;
    do begin step(); negs(); n++; end while (bus.rsp_valid == '0 && n < 100);
    chk("t5_latency", n, TIMEOUT);
    chk("t5_rsp_valid", longint'(bus.rsp_valid), 4'b0010);
    chk("t5_rsp_err", longint'(bus.rsp_err), 1);
    chk("t5_rsp_data", longint'(bus.rsp_data), 0);
    core_hang = 1'b0;
    step(); wait_idle("t5_idle");
    step();

    // Response stalled for 10 cycles with another requester waiting.
    rsp_ready = '0;
    req_data[3] = 32'd100; req_valid = 4'b1000;
    n = 0; negs();
    while (bus.rsp_valid == '0 && n < 100) begin step(); negs(); n++; end
    step();
    req_data[1] = 32'd7; req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      negs();
      chk($sformatf("t4_hold_valid_%0d", i), longint'(bus.rsp_valid), 4'b1000);
      chk($sformatf("t4_hold_data_%0d", i), longint'(bus.rsp_data), 10);
      chk($sformatf("t4_no_ready_%0d", i), longint'(bus.req_ready), 0);
      step();
    end
    sz0 = rsp_log.size();
    rsp_ready = '1;
    negs();
    chk("t4_handshake", rsp_log.size(), sz0 + 1);
    chk("t4_handshake_data", q_at(sz0, 1), 10);
    step(); negs();
    chk("t4_next_accept", longint'(bus.req_ready), 4'b0010);
    step(); wait_idle("t4_idle");
    step();

    // Reset during WAIT, then a clean request.
    req_data[2] = 32'd50000; req_valid = 4'b0100;
    wait_start("t6_start");
    repeat (5) begin step(); negs(); end
    step();
    reset_n = 1'b0; req_valid = '0;
    negs();
    chk("t6_rst_req_ready", longint'(bus.req_ready), 0);
    chk("t6_rst_rsp_valid", longint'(bus.rsp_valid), 0);
    chk("t6_rst_rsp_err", longint'(bus.rsp_err), 0);
    chk("t6_rst_rsp_data", longint'(bus.rsp_data), 0);
    chk("t6_rst_core_start", longint'(core_start), 0);
    chk("t6_rst_core_radicand", longint'(core_radicand), 0);
    chk("t6_rst_sched_busy", longint'(sched_busy), 0);
    chk("t6_rst_grant_id", longint'(grant_id), 0);
    step(); negs(); step();
    reset_n = 1'b1;
    sz0 = rsp_log.size();
    req_data[1] = 32'd81; req_valid = 4'b0010;
    wait_rsp("t6_rsp", sz0 + 1);
    chk("t6_root", q_at(sz0, 1), 9);
    step();

    // Randomized traffic: checked cycle by cycle by the model.
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 3) begin
          req_valid[i] = 1'b1;
          req_data[i]  = rand_data();
        end
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      stray     = ($urandom_range(0, 99) < 3);
      core_lat  = ($urandom_range(0, 9) < 7) ? 17 : int'($urandom_range(1, 40));
      core_hang = ($urandom_range(0, 19) == 0);
      negs();
      step();
    end
    stray = 1'b0; core_hang = 1'b0; rsp_ready = '1; req_valid = '0;
    wait_idle("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_scheduler.md
# sqrt_scheduler

Round-robin scheduler that shares one square-root core among `NREQ` requesters, such as CPU bus ports or pipeline stages. It arbitrates pending requests, issues a one-cycle start pulse with the winning radicand, and waits for the core's done pulse. It returns the root to the originating requester over a valid/ready response channel and flags the request as an error if the core fails to finish within `TIMEOUT` cycles. It sits between the requesters and the square-root core; the core's `busy`/`done`/`root` outputs are wired directly into this block.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 32: maximum cycles from start pulse to core done before an error response.
- `clk` in 1: system clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: requester i has a radicand pending.
- `req_data` in NREQ×32: radicand per requester.
- `req_ready` out NREQ: one-hot accept; request i is taken on a cycle with `req_valid[i] && req_ready[i]`.
- `rsp_valid` out NREQ: one-hot; response is for requester i.
- `rsp_ready` in NREQ: requester i consumes the response.
- `rsp_data` out 32: root, zero-extended from 16 bits; 0 on error.
- `rsp_err` out 1: qualifies `rsp_data`; 1 means timeout.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_radicand` out 32: radicand to the core, held stable from the start pulse until done.
- `core_root` in 32: core result, valid in the `core_done` cycle.
- `core_busy` in 1: core is computing.
- `core_done` in 1: one-cycle core completion pulse.
- `sched_busy` out 1: high in any state other than IDLE.
- `grant_id` out 3: index of the requester currently being served; holds its last value while idle.

## Operation
- **States:**
  - IDLE: arbitrate.
  - ISSUE: drive `core_start`.
  - WAIT: wait for `core_done`.
  - RESP: present the response.
- **IDLE:**
  - If any `req_valid` is set, the round-robin winner w gets `req_ready[w]=1` combinationally.
  - On that edge: latch `req_data[w]` into the radicand register, set `grant_id=w`, move the pointer to w+1 mod NREQ, go to ISSUE.
- **Round-robin rule:** priority starts at the pointer and searches upward with wrap. The pointer resets to 0.
- **ISSUE:** `core_start=1` for exactly one cycle, clear the watchdog counter, go to WAIT.
- **WAIT:**
  - The watchdog increments each cycle.
  - When `core_done=1`: capture `core_root` into the result, set `err=0`, go to RESP.
  - Else when the watchdog reaches `TIMEOUT`: set result=0, `err=1`, go to RESP.
  - `core_done` arriving in the same cycle the watchdog expires counts as success.
- **RESP:**
  - `rsp_valid[grant_id]=1`, with `rsp_data`/`rsp_err` stable until `rsp_ready[grant_id]`.
  - On that handshake, go to IDLE.
  - A requester holding `rsp_ready` low stalls the scheduler indefinitely.
- **Request lifetime:** a requester gets only one outstanding request. `req_ready` is 0 in ISSUE, WAIT and RESP, so a requester may keep `req_valid` high but is not accepted again until the scheduler returns to IDLE.
- **Stray core pulses:** `core_done` outside WAIT is ignored. `core_busy` is informational; it is not used for control.

## Timing
- **Reset values:**
  - `req_ready`, `rsp_valid`, `rsp_err`, `core_start`, `sched_busy`: 0.
  - `rsp_data`, `core_radicand`: 0.
  - `grant_id`: 0; state: IDLE.
- **Reset mid-operation:** the scheduler abandons the request and loses the response. The core shares the same reset net (inverted to its active-high reset), so it also returns to idle.
- **Latency with the standard core (16 iterations plus a DONE cycle):**
  - Accept edge at end of cycle 0.
  - `core_start` in cycle 1.
  - `core_done` in cycle 18.
  - `rsp_valid` from cycle 19.
- **Back-to-back:** the earliest next accept is the cycle after the response handshake, in IDLE. Best-case throughput is one request per 20 cycles.
- **No combinational paths** except from `req_valid` to `req_ready` in IDLE, through the arbiter.

## Structure
- **Package `sqrt_sched_pkg`:** state enum `sched_state_t` {IDLE, ISSUE, WAIT, RESP} and the `ROOT_W=16` constant.
- **Sub-module `rr_arbiter`:** combinational round-robin pick, parameterised by N. Inputs are the request vector and the pointer; outputs are the one-hot grant and its index.
- **Top level:** the FSM, the radicand, result, error and watchdog registers, and the pointer live in `sqrt_scheduler`.

## Test plan
- Single request, radicand 144 from requester 0:
  - `core_start` in cycle 1.
  - `rsp_valid[0]` in cycle 19 with `rsp_data`=12, `rsp_err`=0.
- Requesters 0 and 2 request after reset, radicands 0xFFFFFFFF and 2 → requester 0 is served first (65535), then requester 2 (1); the pointer ends at 3.
- All 4 requesters hold `req_valid` continuously → grants go 0,1,2,3,0.
- Hold `rsp_ready` low for 10 cycles → `rsp_valid`/`rsp_data` are stable, no `req_ready` is raised, and the handshake completes when `rsp_ready` goes high.
- Stub core that never raises done, `TIMEOUT`=32 → response 32 cycles after `core_start` with `rsp_err`=1 and `rsp_data`=0.
- Assert `reset_n`=0 during WAIT → all outputs return to reset values. After release, radicand 81 completes with result 9.
